// File: rtl/rq_stream_arbiter.sv
// -----------------------------------------------------------------------------
// rq_stream_arbiter
//
// Packet-granular round-robin arbiter that shares the single Requester Request
// (RQ) AXI-Stream port of the UltraScale PCIe PHY between N_PORTS requester
// sources (DMA reader, DMA writer, MSI, ...). A source keeps the grant from
// its first beat through tlast, so packets are never interleaved. Accepted
// beats go through a 2-entry skid FIFO, which means s_axis_rq_tready has no
// combinational path back to the sources.
//
// Optional feature (compile-time macro RQ_ARB_STATS_EN):
//   defined   -> pkt_count carries one 16-bit wrapping packet counter per port
//   undefined -> pkt_count is tied to zero and no counter flops are built
//
// Ports:
//   user_clk, user_reset   PHY user clock; asynchronous active-high reset
//   req_tdata/tkeep/tuser  per-source beat fields; port i in slice i
//   req_tlast, req_tvalid  per-source last / valid
//   req_tready             per-source ready; only the selected source sees it
//   s_axis_rq_*            RQ stream towards the PHY (tready bit 0 used)
//   grant                  one-hot owner of a multi-beat packet in flight
//   pkt_count              per-source packet counters, 16 bits per port
// -----------------------------------------------------------------------------
module rq_stream_arbiter #(
    parameter int N_PORTS    = 2,
    parameter int DATA_WIDTH = 256,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 60
) (
    input  logic                           user_clk,
    input  logic                           user_reset,

    input  logic [N_PORTS*DATA_WIDTH-1:0]  req_tdata,
    input  logic [N_PORTS*KEEP_WIDTH-1:0]  req_tkeep,
    input  logic [N_PORTS*USER_WIDTH-1:0]  req_tuser,
    input  logic [N_PORTS-1:0]             req_tlast,
    input  logic [N_PORTS-1:0]             req_tvalid,
    output logic [N_PORTS-1:0]             req_tready,

    output logic [DATA_WIDTH-1:0]          s_axis_rq_tdata,
    output logic [KEEP_WIDTH-1:0]          s_axis_rq_tkeep,
    output logic [USER_WIDTH-1:0]          s_axis_rq_tuser,
    output logic                           s_axis_rq_tlast,
    output logic                           s_axis_rq_tvalid,
    input  logic [3:0]                     s_axis_rq_tready,

    output logic [N_PORTS-1:0]             grant,
    output logic [N_PORTS*16-1:0]          pkt_count
);

    localparam int IDX_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int BEAT_W = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;     // last port that completed a packet
    logic [IDX_W-1:0]   owner;      // port holding the grant while BUSY

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [N_PORTS-1:0] win_onehot;

    logic [IDX_W-1:0]   sel_idx;
    logic               sel_active;
    logic               sel_valid;
    logic               sel_last;
    logic [BEAT_W-1:0]  in_beat;

    logic               in_ready;   // skid has room, registered
    logic               push;
    logic               pop;
    logic [1:0]         skid_cnt;
    logic [1:0]         skid_cnt_next;
    logic [1:0]         wr_pos;
    logic [BEAT_W-1:0]  skid_head;
    logic [BEAT_W-1:0]  skid_tail;

    // Only bit 0 of the PHY ready vector is meaningful.
    logic               unused_tready;
    assign unused_tready = &{1'b0, s_axis_rq_tready[3:1]};

    // -------------------------------------------------------------------------
    // Round-robin winner: first valid port after rr_ptr, wrapping at N_PORTS.
    // -------------------------------------------------------------------------
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        // NOTE: every combinational output gets a default before any branch so
        // no path leaves it unassigned and no latch is inferred.
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= N_PORTS; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= N_PORTS) begin
                cand = cand - N_PORTS;
            end
            cand_idx = IDX_W'(cand);
            if (!win_found && req_tvalid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        win_onehot          = '0;
        win_onehot[win_idx] = 1'b1;
    end

    // -------------------------------------------------------------------------
    // Source selection: the owner while BUSY, the round-robin winner in IDLE.
    // -------------------------------------------------------------------------
    always_comb begin
        sel_idx    = (state == BUSY) ? owner : win_idx;
        sel_active = (state == BUSY) || win_found;
        req_tready = '0;
        if (sel_active) begin
            req_tready[sel_idx] = in_ready;
        end
    end

    assign sel_valid = sel_active & req_tvalid[sel_idx];
    assign sel_last  = req_tlast[sel_idx];
    assign push      = in_ready & sel_valid;

    assign in_beat = {req_tdata[sel_idx*DATA_WIDTH +: DATA_WIDTH],
                      req_tkeep[sel_idx*KEEP_WIDTH +: KEEP_WIDTH],
                      req_tuser[sel_idx*USER_WIDTH +: USER_WIDTH],
                      sel_last};

    // -------------------------------------------------------------------------
    // Packet FSM. A single-beat packet completes in IDLE and only moves rr_ptr.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            state  <= IDLE;
            rr_ptr <= IDX_W'(N_PORTS - 1);
            owner  <= '0;
            grant  <= '0;
        end else if (push) begin
            if (state == IDLE) begin
                if (sel_last) begin
                    rr_ptr <= win_idx;
                end else begin
                    state <= BUSY;
                    owner <= win_idx;
                    grant <= win_onehot;
                end
            end else if (sel_last) begin
                state  <= IDLE;
                rr_ptr <= owner;
                grant  <= '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // 2-entry skid FIFO. in_ready is registered from the next occupancy, so it
    // drops on the same edge the second entry fills.
    // -------------------------------------------------------------------------
    assign pop    = (skid_cnt != 2'd0) & s_axis_rq_tready[0];
    assign wr_pos = skid_cnt - {1'b0, pop};

    always_comb begin
        skid_cnt_next = skid_cnt;
        if (push && !pop) begin
            skid_cnt_next = skid_cnt + 2'd1;
        end else if (!push && pop) begin
            skid_cnt_next = skid_cnt - 2'd1;
        end
    end

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            skid_cnt <= 2'd0;
            in_ready <= 1'b0;
        end else begin
            skid_cnt <= skid_cnt_next;
            in_ready <= (skid_cnt_next < 2'd2);
        end
    end

    // NOTE: the skid storage has no reset; skid_cnt alone decides which
    // entries are valid, so clearing the count flushes the FIFO.
    always_ff @(posedge user_clk) begin
        if (pop) begin
            skid_head <= skid_tail;
        end
        // A push into slot 0 overrides the shift above (later assignment wins).
        if (push) begin
            if (wr_pos == 2'd0) begin
                skid_head <= in_beat;
            end else begin
                skid_tail <= in_beat;
            end
        end
    end

    assign {s_axis_rq_tdata, s_axis_rq_tkeep, s_axis_rq_tuser, s_axis_rq_tlast} = skid_head;
    assign s_axis_rq_tvalid = (skid_cnt != 2'd0);

    // -------------------------------------------------------------------------
    // Optional per-port packet counters, bumped on each accepted tlast beat.
    // -------------------------------------------------------------------------
`ifdef RQ_ARB_STATS_EN
    logic [15:0] pkt_cnt_q [N_PORTS];

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            for (int i = 0; i < N_PORTS; i++) begin
                pkt_cnt_q[i] <= 16'd0;
            end
        end else if (push && sel_last) begin
            pkt_cnt_q[sel_idx] <= pkt_cnt_q[sel_idx] + 16'd1;
        end
    end

    always_comb begin
        pkt_count = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            pkt_count[i*16 +: 16] = pkt_cnt_q[i];
        end
    end
`else
    assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_rq_stream_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rq_stream_arbiter
//
// Self-checking bench for rq_stream_arbiter with three sources. A transaction
// model tracks the packet owner, the last served port and the list of beats
// accepted but not yet delivered; from those it predicts req_tready, grant,
// s_axis_rq_tvalid, every delivered beat and the packet counters.
// Build with +define+RQ_ARB_STATS_EN to cover the counter wrap.
// -----------------------------------------------------------------------------
module tb_rq_stream_arbiter;

    localparam int NP = 3;
    localparam int DW = 256;
    localparam int KW = DW / 8;
    localparam int UW = 60;

`ifdef RQ_ARB_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    logic              user_clk = 1'b0;
    logic              user_reset;
    logic [NP*DW-1:0]  req_tdata;
    logic [NP*KW-1:0]  req_tkeep;
    logic [NP*UW-1:0]  req_tuser;
    logic [NP-1:0]     req_tlast;
    logic [NP-1:0]     req_tvalid;
    logic [NP-1:0]     req_tready;
    logic [DW-1:0]     s_axis_rq_tdata;
    logic [KW-1:0]     s_axis_rq_tkeep;
    logic [UW-1:0]     s_axis_rq_tuser;
    logic              s_axis_rq_tlast;
    logic              s_axis_rq_tvalid;
    logic [3:0]        s_axis_rq_tready;
    logic [NP-1:0]     grant;
    logic [NP*16-1:0]  pkt_count;

    rq_stream_arbiter #(
        .N_PORTS    (NP),
        .DATA_WIDTH (DW),
        .KEEP_WIDTH (KW),
        .USER_WIDTH (UW)
    ) dut (
        .user_clk         (user_clk),
        .user_reset       (user_reset),
        .req_tdata        (req_tdata),
        .req_tkeep        (req_tkeep),
        .req_tuser        (req_tuser),
        .req_tlast        (req_tlast),
        .req_tvalid       (req_tvalid),
        .req_tready       (req_tready),
        .s_axis_rq_tdata  (s_axis_rq_tdata),
        .s_axis_rq_tkeep  (s_axis_rq_tkeep),
        .s_axis_rq_tuser  (s_axis_rq_tuser),
        .s_axis_rq_tlast  (s_axis_rq_tlast),
        .s_axis_rq_tvalid (s_axis_rq_tvalid),
        .s_axis_rq_tready (s_axis_rq_tready),
        .grant            (grant),
        .pkt_count        (pkt_count)
    );

    always #5 user_clk = ~user_clk;

    // Bench bookkeeping and transaction model.
    int          n_checks = 0;
    int          n_errors = 0;
    beat_t       src_q [NP][$];     // beats each source still has to send
    beat_t       exp_fifo [$];      // accepted, not yet delivered, in order
    int          owner;             // -1 when no multi-beat packet in flight
    int          last_srv;          // port that most recently finished a packet
    logic [15:0] exp_cnt [NP];
    int          vprob [NP];        // per-source chance (%) to assert tvalid
    int          force_low [NP];    // cycles a source holds tvalid low
    int          rdy_mode;          // 0: PHY stalls, 1: PHY ready, 2: random

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t rand_beat(input bit last);
        beat_t b;
        for (int w = 0; w < DW / 32; w++) begin
            b.data[w*32 +: 32] = $urandom;
        end
        b.keep = KW'($urandom);
        b.user = UW'({$urandom, $urandom});
        b.last = last;
        return b;
    endfunction

    task automatic add_pkt(input int p, input int len);
        for (int i = 0; i < len; i++) begin
            src_q[p].push_back(rand_beat(i == len - 1));
        end
    endtask

    function automatic logic [NP*16-1:0] exp_pkt_count();
        logic [NP*16-1:0] r;
        r = '0;
        for (int p = 0; p < NP; p++) begin
            r[p*16 +: 16] = STATS_ON ? exp_cnt[p] : 16'd0;
        end
        return r;
    endfunction

    function automatic int pending();
        int n;
        n = exp_fifo.size();
        for (int p = 0; p < NP; p++) begin
            n += src_q[p].size();
        end
        return n;
    endfunction

    function automatic void model_clear();
        exp_fifo.delete();
        for (int p = 0; p < NP; p++) begin
            src_q[p].delete();
            exp_cnt[p]   = 16'd0;
            force_low[p] = 0;
        end
        owner    = -1;
        last_srv = NP - 1;
    endfunction

    // One clock cycle: entered and left at the falling edge.
    task automatic step();
        logic [NP-1:0] v;
        logic [NP-1:0] exp_rdy;
        logic [NP-1:0] exp_grant;
        bit            in_rdy;
        bit            rdy0;
        bit            pop;
        int            win;
        int            acc;
        beat_t         b;
        beat_t         hb;

        v = '0;
        for (int p = 0; p < NP; p++) begin
            b = '0;
            if (src_q[p].size() > 0) begin
                b = src_q[p][0];
                if (force_low[p] > 0) begin
                    force_low[p]--;
                end else begin
                    v[p] = ($urandom_range(0, 99) < vprob[p]);
                end
            end
            req_tdata[p*DW +: DW] = b.data;
            req_tkeep[p*KW +: KW] = b.keep;
            req_tuser[p*UW +: UW] = b.user;
            req_tlast[p]          = b.last;
        end
        req_tvalid = v;
        case (rdy_mode)
            0:       rdy0 = 1'b0;
            1:       rdy0 = 1'b1;
            default: rdy0 = ($urandom_range(0, 99) < 70);
        endcase
        s_axis_rq_tready = {3'($urandom_range(0, 7)), rdy0};
        #1;

        // Expected handshake from the packet-level rules.
        in_rdy  = (exp_fifo.size() < 2);
        exp_rdy = '0;
        win     = -1;
        if (owner >= 0) begin
            if (in_rdy) exp_rdy[owner] = 1'b1;
        end else begin
            for (int k = 1; k <= NP; k++) begin
                int p;
                p = (last_srv + k) % NP;
                if (win < 0 && v[p]) win = p;
            end
            if (win >= 0 && in_rdy) exp_rdy[win] = 1'b1;
        end
        exp_grant = '0;
        if (owner >= 0) exp_grant[owner] = 1'b1;

        check("req_tready", DW'(req_tready), DW'(exp_rdy));
        check("grant", DW'(grant), DW'(exp_grant));
        check("tvalid", DW'(s_axis_rq_tvalid), DW'(exp_fifo.size() > 0));

        pop = (exp_fifo.size() > 0) && rdy0;
        if (pop) begin
            hb = exp_fifo.pop_front();
            check("out_tdata", s_axis_rq_tdata, hb.data);
            check("out_tkeep", DW'(s_axis_rq_tkeep), DW'(hb.keep));
            check("out_tuser", DW'(s_axis_rq_tuser), DW'(hb.user));
            check("out_tlast", DW'(s_axis_rq_tlast), DW'(hb.last));
        end

        acc = -1;
        for (int p = 0; p < NP; p++) begin
            if (exp_rdy[p] && v[p]) acc = p;
        end
        if (acc >= 0) begin
            b = src_q[acc].pop_front();
            exp_fifo.push_back(b);
            if (b.last) begin
                last_srv     = acc;
                owner        = -1;
                exp_cnt[acc] = exp_cnt[acc] + 16'd1;
            end else begin
                owner = acc;
            end
        end

        @(posedge user_clk);
        @(negedge user_clk);
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while (pending() != 0 && n < max_cycles) begin
            step();
            n++;
        end
        check("drain_budget", DW'(pending()), DW'(0));
        check("pkt_count", DW'(pkt_count), DW'(exp_pkt_count()));
    endtask

    // Async reset pulse taken mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        #2 user_reset = 1'b1;
        #1;
        model_clear();
        check("rst_tvalid", DW'(s_axis_rq_tvalid), DW'(exp_fifo.size() > 0));
        check("rst_req_tready", DW'(req_tready), DW'(0));
        check("rst_grant", DW'(grant), DW'(0));
        check("rst_pkt_count", DW'(pkt_count), DW'(exp_pkt_count()));
        @(negedge user_clk);
        user_reset = 1'b0;
        req_tvalid = '0;
        @(posedge user_clk);
        @(negedge user_clk);
    endtask

    initial begin
        model_clear();
        rdy_mode = 1;
        for (int p = 0; p < NP; p++) vprob[p] = 100;

        // Reset state with every source requesting.
        user_reset = 1'b1;
        req_tvalid = '1;
        req_tlast  = '0;
        req_tkeep  = '1;
        req_tuser  = '0;
        for (int w = 0; w < NP * DW / 32; w++) req_tdata[w*32 +: 32] = $urandom;
        s_axis_rq_tready = 4'hF;
        @(negedge user_clk);
        #1;
        check("init_tvalid", DW'(s_axis_rq_tvalid), DW'(0));
        check("init_req_tready", DW'(req_tready), DW'(0));
        check("init_grant", DW'(grant), DW'(0));
        check("init_pkt_count", DW'(pkt_count), DW'(exp_pkt_count()));
        @(negedge user_clk);
        user_reset = 1'b0;
        req_tvalid = '0;
        @(posedge user_clk);
        @(negedge user_clk);

        // Single 3-beat packet from port 0, PHY always ready.
        add_pkt(0, 3);
        drain(50);

        // All sources saturated with 2-beat packets: strict rotation, no gaps.
        for (int r = 0; r < 4; r++) begin
            for (int p = 0; p < NP; p++) add_pkt(p, 2);
        end
        drain(200);

        // Port 1 owns a packet and bubbles for 3 cycles while port 0 waits.
        add_pkt(1, 4);
        step();
        add_pkt(0, 2);
        force_low[1] = 3;
        drain(100);

        // PHY stalls 5 cycles in the middle of a burst: skid fills, ready drops.
        add_pkt(2, 8);
        step();
        step();
        rdy_mode = 0;
        repeat (5) step();
        rdy_mode = 1;
        drain(100);

        // Back-to-back single-beat packets from ports 0 and 1.
        for (int r = 0; r < 6; r++) begin
            add_pkt(0, 1);
            add_pkt(1, 1);
        end
        drain(100);

        // Random packets, random bubbles, random PHY backpressure.
        rdy_mode = 2;
        for (int p = 0; p < NP; p++) vprob[p] = $urandom_range(30, 100);
        for (int i = 0; i < 40; i++) begin
            add_pkt($urandom_range(0, NP - 1), $urandom_range(1, 5));
        end
        drain(4000);

        // Reset in the middle of a packet, then traffic resumes cleanly.
        rdy_mode = 1;
        for (int p = 0; p < NP; p++) vprob[p] = 100;
        add_pkt(0, 5);
        step();
        step();
        do_reset();
        add_pkt(1, 2);
        add_pkt(2, 1);
        drain(50);

`ifdef RQ_ARB_STATS_EN
        // Counter wrap: 65537 single-beat packets leave port 0 at 1.
        for (int i = 0; i < 65537; i++) add_pkt(0, 1);
        drain(70000);
        check("wrap_port0", DW'(pkt_count[15:0]), DW'(exp_cnt[0]));
        do_reset();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rq_stream_arbiter.md
Name: rq_stream_arbiter

Overview:
- Packet-granular round-robin arbiter. Shares the single 256-bit Requester Request (RQ) AXI-Stream port of the Xilinx UltraScale PCIe PHY between N requester sources, such as the DMA reader, DMA writer and MSI.
- Sits between the LitePCIe TLP packetizers and the RQ adapter. A grant is held for a whole packet (tvalid through tlast) and is never interleaved.
- Output passes through a 2-entry skid register, so s_axis_rq_tready has no combinational path back to the sources.

Parameters:
- N_PORTS, 2, number of requester sources (2..8).
- DATA_WIDTH, 256, stream data width.
- KEEP_WIDTH, DATA_WIDTH/8, byte-enable width.
- USER_WIDTH, 60, RQ tuser width.

Ports:
- user_clk  in  1  PHY user clock; the only clock.
- user_reset  in  1  reset, asynchronous and active-high.
- req_tdata  in  N_PORTS*DATA_WIDTH  per-source data; port i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- req_tkeep  in  N_PORTS*KEEP_WIDTH  per-source keep.
- req_tuser  in  N_PORTS*USER_WIDTH  per-source tuser.
- req_tlast  in  N_PORTS  per-source last.
- req_tvalid  in  N_PORTS  per-source valid.
- req_tready  out  N_PORTS  per-source ready.
- s_axis_rq_tdata  out  DATA_WIDTH  to PHY.
- s_axis_rq_tkeep  out  KEEP_WIDTH  to PHY.
- s_axis_rq_tuser  out  USER_WIDTH  to PHY.
- s_axis_rq_tlast  out  1  to PHY.
- s_axis_rq_tvalid  out  1  to PHY.
- s_axis_rq_tready  in  4  from PHY; only bit 0 is used.
- grant  out  N_PORTS  one-hot current owner; all zero when no packet is in flight.
- pkt_count  out  N_PORTS*16  per-source packet counters (optional feature).

Behaviour:
- Reset (async assert, deassert sampled on user_clk):
  - state=IDLE; rr_ptr=N_PORTS-1, so port 0 has first priority.
  - skid empty; s_axis_rq_tvalid=0; req_tready=0; grant=0; pkt_count=0.
- Input acceptance: in_ready = skid entries < 2, registered, from the previous cycle's occupancy.
- IDLE:
  - Winner = first asserted req_tvalid searching rr_ptr+1, rr_ptr+2, ... modulo N_PORTS. Combinational; no idle cycle.
  - req_tready[winner] = in_ready; all other req_tready bits = 0.
  - On winner beat accepted with tlast=0: go to BUSY, owner<=winner, grant<=onehot(winner).
  - On winner beat accepted with tlast=1 (single-beat TLP): stay in IDLE, rr_ptr<=winner.
  - Nothing accepted: no state change.
- BUSY:
  - req_tready[owner] = in_ready; all other bits = 0.
  - The owner may drop tvalid mid-packet (bubbles); the grant is held and no other source is served.
  - On owner tlast accepted: go to IDLE, rr_ptr<=owner, grant<=0. The next packet may be granted the following cycle.
- Skid/output:
  - Accepted beat {tdata,tkeep,tuser,tlast} is written to the skid, FIFO order.
  - s_axis_rq_tvalid = skid non-empty; head beat is presented.
  - Pop on s_axis_rq_tvalid & s_axis_rq_tready[0].
  - Latency input-accept to tvalid = 1 cycle; sustained throughput 1 beat/cycle.
  - Simultaneous push and pop keeps occupancy unchanged.
  - Output fields hold stable while tvalid=1 and tready[0]=0.
- Fairness: with all N_PORTS continuously requesting, ports are served in order i, i+1, ... modulo N_PORTS. No port waits more than N_PORTS-1 packets.
- Reset mid-packet: the skid is flushed and the partial packet is dropped downstream. Sources must also be reset by the same user_reset.

Optional Feature:
- Macro: RQ_ARB_STATS_EN.
- Defined:
  - pkt_count[i*16 +: 16] increments by 1 on each accepted tlast beat from port i.
  - Wraps 0xFFFF->0x0000; reset to 0.
- Undefined: pkt_count tied to 0; no counter flops.

Test Plan:
1. Single source, port 0 sends a 3-beat TLP with the PHY always ready -> s_axis_rq_tvalid 1 cycle after the first accept; 3 beats in order; tlast on beat 3; grant=0b01 during beats 1-2, then 0.
2. N_PORTS=2, both sources hold valid with 2-beat packets continuously -> output packet owners alternate 0,1,0,1; never interleaved; no idle cycle between packets.
3. Port 1 in BUSY drops tvalid for 3 cycles mid-packet while port 0 is valid -> req_tready[0] stays 0; port 1's packet completes contiguously before port 0 is granted.
4. s_axis_rq_tready[0] held 0 for 5 cycles during a burst -> skid fills to 2; req_tready falls the cycle after; no beat lost or duplicated; output stable.
5. Single-beat TLPs (tlast=1 on the first beat) from ports 0 and 1 back-to-back -> one beat per cycle, alternating owners; grant stays 0.
6. RQ_ARB_STATS_EN defined, 65537 single-beat packets on port 0 -> pkt_count[15:0]=1; async user_reset pulse -> counters 0 and tvalid 0 immediately.
